// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus bundle: ROM access, decode-side valid/ready output and the
// redirect (branch / flush) inputs. The fetch controller uses the master view,
// the surrounding environment (ROM, decode, trap logic) uses the slave view.
interface if_fetch_ctrl_if;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
        input  rom_inst_i, id_ready_i, branch_i, branch_target_i, flush_i, flush_pc_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
        output rom_inst_i, id_ready_i, branch_i, branch_target_i, flush_i, flush_pc_i
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control stage.
// Owns the PC, drives the instruction ROM and presents {pc, inst} to decode
// through a one-entry registered valid/ready slot. Handles back-pressure,
// branch redirect, flush and a sticky halt on misaligned redirect targets.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch/stall performance
// counters; without it both counter outputs are tied to zero.
//
// state | meaning
// IDLE  | one cycle after reset release, ROM disabled
// FETCH | ROM enabled at pc, capture into output slot when it is free
// HALT  | misaligned redirect target seen, nothing fetched until aligned flush
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_ctrl_if.master bus,
    output logic           misalign_o,
    output logic [31:0]    perf_fetch_o,
    output logic [31:0]    perf_stall_o
);

    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        slot_free;
    logic        in_fetch;
    logic        do_capture;

    assign slot_free  = !id_valid || bus.id_ready_i;
    assign in_fetch   = (state == FETCH);
    // Flush outranks branch, branch outranks the sequential fetch.
    assign do_capture = in_fetch && !bus.flush_i && !bus.branch_i && slot_free;

    assign bus.rom_ce_o   = in_fetch ? CHIP_ENABLE : CHIP_DISABLE;
    assign bus.rom_addr_o = pc;
    assign bus.id_valid_o = id_valid;
    assign bus.id_pc_o    = id_pc;
    assign bus.id_inst_o  = id_inst;

    // Fetch FSM, PC and output slot; redirects discard any unaccepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            id_valid   <= 1'b0;
            id_pc      <= ZERO_WORD;
            id_inst    <= ZERO_WORD;
            misalign_o <= 1'b0;
        end else if (bus.flush_i) begin
            id_valid <= 1'b0;
            pc       <= bus.flush_pc_i;
            if (bus.flush_pc_i[1:0] != 2'b00) begin
                misalign_o <= 1'b1;
                state      <= HALT;
            end else begin
                misalign_o <= 1'b0;
                state      <= FETCH;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (bus.branch_i) begin
                        id_valid <= 1'b0;
                        pc       <= bus.branch_target_i;
                        if (bus.branch_target_i[1:0] != 2'b00) begin
                            misalign_o <= 1'b1;
                            state      <= HALT;
                        end
                    end else if (slot_free) begin
                        id_valid <= 1'b1;
                        id_pc    <= pc;
                        id_inst  <= bus.rom_inst_i;
                        pc       <= pc + 32'(PC_STEP);
                    end
                end
                HALT: begin
                    id_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic do_stall;

    assign do_stall = in_fetch && !bus.flush_i && !bus.branch_i && !slot_free;

    // Free-running performance counters, wrap at 2^32, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_o <= 32'h0;
            perf_stall_o <= 32'h0;
        end else begin
            if (do_capture) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (do_stall) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`else
    logic unused_capture;

    assign unused_capture = do_capture;
    assign perf_fetch_o   = 32'h0;
    assign perf_stall_o   = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl. The stimulus side keeps a
// transaction-level model (fetch pointer, run/halt phase, queue of words
// expected at decode) and pushes expected words; a negedge monitor pops and
// compares them on every decode handshake.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        misalign;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;

    if_fetch_ctrl_if fif ();

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (fif),
        .misalign_o   (misalign),
        .perf_fetch_o (perf_fetch),
        .perf_stall_o (perf_stall)
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign fif.rom_inst_i = rom_fn(fif.rom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // model: phase 0 = waiting after reset, 1 = running, 2 = halted
    int          cur_phase;
    logic [31:0] cur_pc;
    logic        cur_mis;
    logic        cur_valid;
    logic [31:0] cur_pf;
    logic [31:0] cur_ps;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_phase = 0;
        cur_pc    = 32'h0;
        cur_mis   = 1'b0;
        cur_valid = 1'b0;
        cur_pf    = 32'h0;
        cur_ps    = 32'h0;
    endtask

    task automatic drive_idle();
        fif.id_ready_i      = 1'b0;
        fif.branch_i        = 1'b0;
        fif.branch_target_i = 32'h0;
        fif.flush_i         = 1'b0;
        fif.flush_pc_i      = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_ce"},   {31'b0, fif.rom_ce_o},   32'h0);
        chk({tag, "_rom_addr"}, fif.rom_addr_o,          32'h0);
        chk({tag, "_id_valid"}, {31'b0, fif.id_valid_o}, 32'h0);
        chk({tag, "_id_pc"},    fif.id_pc_o,             32'h0);
        chk({tag, "_id_inst"},  fif.id_inst_o,           32'h0);
        chk({tag, "_misalign"}, {31'b0, misalign},       32'h0);
        chk({tag, "_perf_f"},   perf_fetch,              32'h0);
        chk({tag, "_perf_s"},   perf_stall,              32'h0);
    endtask

    // One cycle: apply inputs, advance the model to the post-edge view.
    task automatic step(input logic r, input logic b, input logic [31:0] bt,
                        input logic f, input logic [31:0] fp);
        int          n_phase;
        logic [31:0] n_pc, n_pf, n_ps;
        logic        n_mis, n_valid, cap, discard;
        fif.id_ready_i      = r;
        fif.branch_i        = b;
        fif.branch_target_i = bt;
        fif.flush_i         = f;
        fif.flush_pc_i      = fp;
        n_phase = cur_phase; n_pc = cur_pc; n_mis = cur_mis;
        n_pf = cur_pf; n_ps = cur_ps;
        cap = 1'b0; discard = 1'b0;
        if (f) begin
            discard = 1'b1;
            n_pc    = fp;
            n_mis   = (fp[1:0] != 2'b00);
            n_phase = n_mis ? 2 : 1;
        end else if (cur_phase == 0) begin
            n_phase = 1;
        end else if (cur_phase == 1 && b) begin
            discard = 1'b1;
            n_pc    = bt;
            if (bt[1:0] != 2'b00) begin
                n_mis   = 1'b1;
                n_phase = 2;
            end
        end else if (cur_phase == 1) begin
            if (!cur_valid || r) begin
                cap = 1'b1;
                exp_q.push_back({cur_pc, rom_fn(cur_pc)});
                n_pc = cur_pc + 32'd4;
                n_pf = cur_pf + 32'd1;
            end else begin
                n_ps = cur_ps + 32'd1;
            end
        end
        if (discard && cur_valid && !r) void'(exp_q.pop_front());
        n_valid = cap || (cur_valid && !r && !discard);
        @(posedge clk);
        #1;
        cur_phase = n_phase; cur_pc = n_pc; cur_mis = n_mis;
        cur_valid = n_valid; cur_pf = n_pf; cur_ps = n_ps;
    endtask

    task automatic seq(input int n, input logic r);
        for (int i = 0; i < n; i++) step(r, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: compare DUT against the model and pop on each decode handshake.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && mon_en) begin
            chk("rom_ce",   {31'b0, fif.rom_ce_o},   {31'b0, (cur_phase == 1)});
            chk("rom_addr", fif.rom_addr_o,          cur_pc);
            chk("id_valid", {31'b0, fif.id_valid_o}, {31'b0, cur_valid});
            chk("misalign", {31'b0, misalign},       {31'b0, cur_mis});
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch, cur_pf);
            chk("perf_stall", perf_stall, cur_ps);
`else
            chk("perf_fetch", perf_fetch, 32'h0);
            chk("perf_stall", perf_stall, 32'h0);
`endif
            if (fif.id_valid_o && fif.id_ready_i) begin
                if (!cur_valid || exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL handshake actual=unexpected pc %h required=no word", fif.id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc",   fif.id_pc_o,   e[63:32]);
                    chk("id_inst", fif.id_inst_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] bt, fp;
        logic        r, b, f;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_reset_outputs("por");
        do_reset();
        mon_en = 1'b1;

        // sequential start, then three-cycle stall at pc=8
        seq(3, 1'b1);
        seq(3, 1'b0);
        chk("stall_addr", fif.rom_addr_o, 32'h8);
        chk("stall_id_pc", fif.id_pc_o, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", perf_stall, 32'd3);
`endif
        seq(2, 1'b1);
        chk("resume_id_pc", fif.id_pc_o, 32'hC);

        // branch at pc=0x10 to 0x40
        step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("br_valid", {31'b0, fif.id_valid_o}, 32'h0);
        seq(1, 1'b1);
        chk("br_id_pc", fif.id_pc_o, 32'h40);

        // misaligned branch target halts; branch ignored in halt; flush resumes
        step(1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
        chk("mis_flag", {31'b0, misalign}, 32'h1);
        chk("mis_ce", {31'b0, fif.rom_ce_o}, 32'h0);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
        chk("halt_addr", fif.rom_addr_o, 32'h42);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        seq(1, 1'b1);
        chk("flush_id_pc", fif.id_pc_o, 32'h80);
        chk("flush_mis", {31'b0, misalign}, 32'h0);

        // flush beats branch in the same cycle
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
        chk("prio_pc", fif.rom_addr_o, 32'h100);

        // pc wrap, then reset in the middle of a stall
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        seq(3, 1'b1);
        chk("wrap_id_pc", fif.id_pc_o, 32'h0);
        chk("wrap_addr", fif.rom_addr_o, 32'h4);
        seq(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        do_reset();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 11) == 0);
            f  = ($urandom_range(0, 24) == 0);
            bt = $urandom & 32'hFFFF_FFFC;
            fp = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) fp[1:0] = 2'($urandom_range(1, 3));
            step(r, b, bt, f, fp);
        end
        seq(3, 1'b1);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
